// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and widths for the LED LFSR sequencer.
package lfsr_ctrl_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LFSR_W = 8;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-FF sync -> stability debounce -> one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam logic [DEB_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_sync;
    logic             r_level;
    logic [DEB_W-1:0] r_cnt;
    logic             r_press;

    // Level only follows the synced input after it has disagreed for 2^DEB_W cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Button-driven run/step/reseed sequencer for the 8-bit LFSR, with step and period counters.
module lfsr_seq_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned        TICK_DIV = 23,
    parameter int unsigned        DEB_W    = 16,
    parameter logic [LFSR_W-1:0]  SEED     = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_run_n,
    input  logic              btn_step_n,
    input  logic              btn_clr_n,
    input  logic [LFSR_W-1:0] lfsr_state,
    output logic              lfsr_step,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic              running,
    output logic [CNT_W-1:0]  step_cnt,
    output logic [CNT_W-1:0]  period_len,
    output logic              period_done
);

    logic                w_run_press;
    logic                w_step_press;
    logic                w_clr_press;
    state_e              r_state;
    state_e              w_next;
    logic [TICK_DIV-1:0] r_presc;
    logic                w_tick;
    logic                w_step;
    logic                w_load;
    logic                w_detect;
    logic                r_step_d;
    logic [CNT_W-1:0]    r_step_cnt;
    logic [CNT_W-1:0]    r_period_len;

    btn_debounce #(.DEB_W(DEB_W)) u_deb_run (
        .clk(clk), .rst_n(rst_n), .i_btn_n(btn_run_n), .o_press(w_run_press)
    );
    btn_debounce #(.DEB_W(DEB_W)) u_deb_step (
        .clk(clk), .rst_n(rst_n), .i_btn_n(btn_step_n), .o_press(w_step_press)
    );
    btn_debounce #(.DEB_W(DEB_W)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .i_btn_n(btn_clr_n), .o_press(w_clr_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PAUSE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority on coincident events: clr, then run, then step/tick
    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        w_load = 1'b0;
        case (r_state)
            PAUSE: begin
                if (w_clr_press)       w_next = LOAD;
                else if (w_run_press)  w_next = RUN;
                else if (w_step_press) w_step = 1'b1;
            end
            RUN: begin
                if (w_clr_press)      w_next = LOAD;
                else if (w_run_press) w_next = PAUSE;
                else if (w_tick)      w_step = 1'b1;
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = PAUSE;
            end
            default: w_next = PAUSE;
        endcase
    end

    // Held at zero outside RUN so every entry to RUN restarts the full interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= r_presc + TICK_DIV'(1);
        end else begin
            r_presc <= '0;
        end
    end

    assign w_tick   = (r_state == RUN) && (&r_presc);
    assign w_detect = r_step_d && (lfsr_state == SEED) && (r_state != LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_d     <= 1'b0;
            r_step_cnt   <= '0;
            r_period_len <= '0;
        end else begin
            r_step_d <= w_step;
            if (w_load) begin
                r_step_cnt <= '0;
            end else if (w_detect) begin
                r_period_len <= r_step_cnt;
                r_step_cnt   <= w_step ? CNT_W'(1) : CNT_W'(0);
            end else if (w_step) begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
        end
    end

    assign lfsr_step   = w_step;
    assign lfsr_load   = w_load;
    assign lfsr_seed   = SEED;
    assign running     = (r_state == RUN);
    assign step_cnt    = r_step_cnt;
    assign period_len  = r_period_len;
    assign period_done = w_detect;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl with a de Bruijn LFSR model closing the loop on lfsr_state.
module tb_lfsr_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_run_n;
    logic        btn_step_n;
    logic        btn_clr_n;
    logic [7:0]  lfsr_state;
    logic        lfsr_step;
    logic        lfsr_load;
    logic [7:0]  lfsr_seed;
    logic        running;
    logic [15:0] step_cnt;
    logic [15:0] period_len;
    logic        period_done;

    lfsr_seq_ctrl #(.TICK_DIV(3), .DEB_W(2), .SEED(8'h01)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_run_n(btn_run_n), .btn_step_n(btn_step_n), .btn_clr_n(btn_clr_n),
        .lfsr_state(lfsr_state),
        .lfsr_step(lfsr_step), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .running(running), .step_cnt(step_cnt), .period_len(period_len),
        .period_done(period_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x^8+x^4+x^3+x^2+1 with the all-zero state spliced in after 8'h80
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        if (s[6:0] == 7'd0) fb = ~fb;
        return {s[6:0], fb};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lfsr_state <= 8'h01;
        else if (lfsr_load) lfsr_state <= lfsr_seed;
        else if (lfsr_step) lfsr_state <= lfsr_next(lfsr_state);
    end

    typedef struct {
        logic is_clr;
        int   len;
        int   exp_steps;
        int   exp_loads;
        int   exp_cnt;
    } vec_t;

    vec_t vecs [9];
    int   sb_q [$];
    logic sb_en;
    int   n_cmp, n_err;
    int   cyc, n_step, n_load, n_pd, last_step_cyc;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample outputs mid-cycle, score strobes, then release for driving
    task automatic tick();
        int kind;
        @(negedge clk);
        cyc++;
        if (lfsr_step) begin
            n_step++;
            last_step_cyc = cyc;
        end
        if (lfsr_load)   n_load++;
        if (period_done) n_pd++;
        if (sb_en && (lfsr_step || lfsr_load)) begin
            kind = lfsr_load ? int'("L") : int'("S");
            if (sb_q.size() == 0) chk("sb_unexpected_strobe", kind, 0);
            else                  chk("sb_strobe_kind", kind, sb_q.pop_front());
        end
        #1;
    endtask

    task automatic wait_running(input logic val, input int budget, input string name);
        int k = 0;
        while (running !== val && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(running), int'(val));
    endtask

    task automatic wait_step(input int budget, input string name, output int at);
        int s0 = n_step;
        int k  = 0;
        while (n_step == s0 && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(n_step != s0), 1);
        at = last_step_cyc;
    endtask

    task automatic press(input int which, input int len);
        if (which == 0) btn_step_n = 1'b0;
        else if (which == 1) btn_clr_n = 1'b0;
        else btn_run_n = 1'b0;
        repeat (len) tick();
        btn_step_n = 1'b1;
        btn_clr_n  = 1'b1;
        btn_run_n  = 1'b1;
    endtask

    initial begin
        int s0, l0, pd0, fall, r0, c1, c2, c3, k;
        n_cmp = 0; n_err = 0; cyc = 0; n_step = 0; n_load = 0; n_pd = 0;
        last_step_cyc = 0; sb_en = 1'b0;
        btn_run_n = 1'b1; btn_step_n = 1'b1; btn_clr_n = 1'b1;
        rst_n = 1'b0;

        // is_clr, low cycles, steps, loads, step_cnt afterwards
        vecs[0] = '{1'b0,  1, 0, 0, 0};
        vecs[1] = '{1'b0,  3, 0, 0, 0};
        vecs[2] = '{1'b0,  4, 1, 0, 1};
        vecs[3] = '{1'b0, 12, 1, 0, 2};
        vecs[4] = '{1'b1,  3, 0, 0, 2};
        vecs[5] = '{1'b1,  2, 0, 0, 2};
        vecs[6] = '{1'b0,  8, 1, 0, 3};
        vecs[7] = '{1'b1,  6, 0, 1, 0};
        vecs[8] = '{1'b0,  5, 1, 0, 1};

        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset
        repeat (200) tick();
        chk("idle_steps", n_step, 0);
        chk("idle_loads", n_load, 0);
        chk("idle_period_done", n_pd, 0);
        chk("idle_running", int'(running), 0);
        chk("idle_step_cnt", int'(step_cnt), 0);
        chk("idle_period_len", int'(period_len), 0);
        chk("seed_value", int'(lfsr_seed), 8'h01);

        // Debounce / single-step / reseed vectors in PAUSE
        sb_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < vecs[i].exp_steps; j++) sb_q.push_back(int'("S"));
            for (int j = 0; j < vecs[i].exp_loads; j++) sb_q.push_back(int'("L"));
            s0 = n_step; l0 = n_load; fall = cyc;
            press(vecs[i].is_clr ? 1 : 0, vecs[i].len);
            repeat (20) tick();
            chk($sformatf("vec%0d_steps", i), n_step - s0, vecs[i].exp_steps);
            chk($sformatf("vec%0d_loads", i), n_load - l0, vecs[i].exp_loads);
            chk($sformatf("vec%0d_sb_left", i), sb_q.size(), 0);
            chk($sformatf("vec%0d_step_cnt", i), int'(step_cnt), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_running", i), int'(running), 0);
            if (vecs[i].exp_steps != 0)
                chk($sformatf("vec%0d_latency_ok", i), int'(last_step_cyc - fall <= 8), 1);
            sb_q.delete();
        end
        sb_en = 1'b0;

        // RUN cadence then pause
        press(2, 6);
        wait_running(1'b1, 30, "run_enter");
        r0 = cyc;
        wait_step(20, "run_step1", c1);
        wait_step(20, "run_step2", c2);
        wait_step(20, "run_step3", c3);
        chk("run_first_step_offset", c1 - r0, 7);
        chk("run_step_interval_a", c2 - c1, 8);
        chk("run_step_interval_b", c3 - c2, 8);
        s0 = n_step;
        press(2, 6);
        wait_running(1'b0, 30, "run_exit");
        repeat (40) tick();
        chk("pause_no_steps", n_step - s0, 0);
        chk("pause_step_cnt", int'(step_cnt), 4);

        // Full period from SEED
        press(1, 6);
        repeat (20) tick();
        chk("reseed_step_cnt", int'(step_cnt), 0);
        chk("reseed_model_state", int'(lfsr_state), 8'h01);
        s0 = n_step; pd0 = n_pd;
        press(2, 6);
        k = 0;
        while (n_pd == pd0 && k < 2300) begin
            tick();
            k++;
        end
        chk("period_done_seen", n_pd - pd0, 1);
        chk("period_steps", n_step - s0, 256);
        tick();
        chk("period_len", int'(period_len), 16'h0100);
        chk("period_step_cnt_cleared", int'(step_cnt), 0);

        // Reseed landing on a tick while running
        wait_step(20, "pre_clr_step", k);
        tick();
        tick();
        s0 = n_step; l0 = n_load; pd0 = n_pd;
        press(1, 8);
        repeat (20) tick();
        chk("clr_tick_no_step", n_step - s0, 0);
        chk("clr_tick_one_load", n_load - l0, 1);
        chk("clr_tick_step_cnt", int'(step_cnt), 0);
        chk("clr_tick_running", int'(running), 0);
        chk("clr_tick_model_state", int'(lfsr_state), 8'h01);
        chk("clr_tick_no_period", n_pd - pd0, 0);
        chk("clr_tick_period_kept", int'(period_len), 16'h0100);

        // Coincident run+step in PAUSE, then clr glitch while running
        s0 = n_step;
        btn_run_n = 1'b0;
        press(0, 6);
        wait_running(1'b1, 30, "runstep_enter");
        chk("runstep_no_step", n_step - s0, 0);
        l0 = n_load;
        press(1, 3);
        repeat (20) tick();
        chk("clr_glitch_no_load", n_load - l0, 0);
        chk("clr_glitch_running", int'(running), 1);
        chk("clr_glitch_steps_continue", int'(n_step > s0), 1);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_step_cnt", int'(step_cnt), 0);
        chk("async_rst_period_len", int'(period_len), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        s0 = n_step; l0 = n_load;
        repeat (10) tick();
        chk("post_rst_no_steps", n_step - s0, 0);
        chk("post_rst_no_loads", n_load - l0, 0);
        chk("post_rst_running", int'(running), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
